// File: rtl/openofdm_rx_gate_pkg.sv
// Shared definitions for the RX sensitivity gate: FSM state encodings and the
// width of the gate-open statistics counter.
package openofdm_rx_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } gate_state_t;

  localparam int PASS_CNT_W = 16;

endpackage

// File: rtl/sat_counter_16.sv
// 16-bit incrementer that sticks at all-ones instead of wrapping.
module sat_counter_16
  import openofdm_rx_gate_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [PASS_CNT_W-1:0] cnt
);

  // Count increment requests, holding at the maximum value once reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rssi_sensitivity_gate.sv
// Debounced, hysteretic "signal strong enough" gate: RSSI samples are compared
// against the locked sensitivity threshold; ARM_LEN consecutive strong samples
// open the gate, HOLD_LEN consecutive weak samples (without pkt_busy) close it.
module rssi_sensitivity_gate
  import openofdm_rx_gate_pkg::*;
#(
  parameter int RSSI_HALF_DB_WIDTH_UNSIGNED = 10,
  parameter int ARM_LEN                     = 4,
  parameter int HOLD_LEN                    = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [RSSI_HALF_DB_WIDTH_UNSIGNED-1:0] rssi_half_db,
  input  logic                                   rssi_half_db_valid,
  input  logic [RSSI_HALF_DB_WIDTH_UNSIGNED-1:0] rx_sensitivity_th_lock,
  input  logic                                   pkt_busy,
  output logic                                   sens_pass,
  output logic                                   sens_rise,
  output logic [PASS_CNT_W-1:0]                  sens_pass_cnt,
  output logic [1:0]                             gate_state
);

  localparam int ARM_W  = $clog2(ARM_LEN + 1);
  localparam int HOLD_W = $clog2(HOLD_LEN + 1);

  localparam logic [ARM_W-1:0]  ARM_ONE   = ARM_W'(1);
  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_LEN);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LEN);

  gate_state_t       state;
  gate_state_t       state_nxt;
  logic [ARM_W-1:0]  arm_cnt;
  logic [ARM_W-1:0]  arm_nxt;
  logic [ARM_W-1:0]  arm_inc;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [HOLD_W-1:0] hold_inc;
  logic              above;
  logic              opening;

  // Threshold is compared live; a threshold change never restarts the FSM.
  assign above    = (rssi_half_db >= rx_sensitivity_th_lock);
  assign arm_inc  = arm_cnt + ARM_ONE;
  assign hold_inc = hold_cnt + HOLD_ONE;

  // Next-state and counter update; only valid samples move the FSM, except
  // pkt_busy which pulls HOLD back to ACTIVE on any cycle.
  always_comb begin
    state_nxt = state;
    arm_nxt   = arm_cnt;
    hold_nxt  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (rssi_half_db_valid && above) begin
          if (ARM_LEN == 1) begin
            state_nxt = ST_ACTIVE;
            arm_nxt   = '0;
          end else begin
            state_nxt = ST_ARMING;
            arm_nxt   = ARM_ONE;
          end
        end
      end
      ST_ARMING: begin
        if (rssi_half_db_valid) begin
          if (above) begin
            if (arm_inc == ARM_LAST) begin
              state_nxt = ST_ACTIVE;
              arm_nxt   = '0;
            end else begin
              arm_nxt = arm_inc;
            end
          end else begin
            state_nxt = ST_IDLE;
            arm_nxt   = '0;
          end
        end
      end
      ST_ACTIVE: begin
        if (rssi_half_db_valid && !above && !pkt_busy) begin
          if (HOLD_LEN == 1) begin
            state_nxt = ST_IDLE;
            hold_nxt  = '0;
          end else begin
            state_nxt = ST_HOLD;
            hold_nxt  = HOLD_ONE;
          end
        end
      end
      ST_HOLD: begin
        if (pkt_busy) begin
          state_nxt = ST_ACTIVE;
          hold_nxt  = '0;
        end else if (rssi_half_db_valid) begin
          if (above) begin
            state_nxt = ST_ACTIVE;
            hold_nxt  = '0;
          end else if (hold_inc == HOLD_LAST) begin
            state_nxt = ST_IDLE;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_inc;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        arm_nxt   = '0;
        hold_nxt  = '0;
      end
    endcase
  end

  // State and debounce counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      arm_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      arm_cnt  <= arm_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Only a closed-to-open move counts as a rise; HOLD->ACTIVE is a recovery.
  assign opening = ((state == ST_IDLE) || (state == ST_ARMING)) && (state_nxt == ST_ACTIVE);

  // Rise pulse lines up with the first cycle sens_pass is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sens_rise <= 1'b0;
    end else begin
      sens_rise <= opening;
    end
  end

  // ACTIVE and HOLD share bit 1 of the encoding, so the gate is a flop bit.
  assign sens_pass  = state[1];
  assign gate_state = state;

  sat_counter_16 u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .inc (sens_rise),
    .cnt (sens_pass_cnt)
  );

endmodule

// File: doc/rssi_sensitivity_gate.md
# rssi_sensitivity_gate

Qualifies per-sample RSSI against the locked RX sensitivity threshold and produces a debounced, hysteretic "signal strong enough" gate for the packet-detection front end. It sits directly downstream of the setting agent, consumes its `rx_sensitivity_th_lock`, and feeds short-preamble detection and the receive state machine. The block also counts gate-open events for driver statistics.

## Interface
Parameters:
- `RSSI_HALF_DB_WIDTH_UNSIGNED`, 10: width of RSSI and threshold, unsigned half-dB, larger means stronger.
- `ARM_LEN`, 4: consecutive above-threshold valid samples required to open the gate. Legal range is at least 1.
- `HOLD_LEN`, 16: consecutive below-threshold valid samples required to close the gate. Legal range is at least 1.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: reset, asynchronous and active-high.
- `rssi_half_db` in W: RSSI sample.
- `rssi_half_db_valid` in 1: sample strobe, one cycle per sample.
- `rx_sensitivity_th_lock` in W: threshold from the setting agent.
- `pkt_busy` in 1: demodulation in progress. It forces the gate to stay open.
- `sens_pass` out 1: the gate. Registered.
- `sens_rise` out 1: one-cycle pulse when `sens_pass` goes 0→1.
- `sens_pass_cnt` out 16: saturating count of `sens_rise` events.
- `gate_state` out 2: current FSM state, for debug.

## Operation
Definitions:
- "Above" means `rssi_half_db >= rx_sensitivity_th_lock`, as an unsigned compare.
- The threshold is compared live on every sample. A threshold change never restarts the FSM.
- A threshold of 0 makes every sample "above", which amounts to a bypass after `ARM_LEN` samples.

Sample handling:
- FSM transitions driven by samples are evaluated only on cycles where `rssi_half_db_valid` is 1.
- On cycles with valid low, all state holds, with one exception: the `pkt_busy` rule in HOLD.

FSM states: IDLE, ARMING, ACTIVE, HOLD.
- **IDLE**
  - Above: `arm_cnt`←1. Go to ACTIVE if `ARM_LEN`==1, else to ARMING.
  - Below: stay.
- **ARMING**
  - Above: `arm_cnt`+1. When the new value equals `ARM_LEN`, go to ACTIVE and clear `arm_cnt`.
  - Below: `arm_cnt`←0, go to IDLE.
- **ACTIVE**
  - Above: stay.
  - Below with `pkt_busy`=1: stay.
  - Below with `pkt_busy`=0: `hold_cnt`←1. Go to IDLE if `HOLD_LEN`==1, else to HOLD.
- **HOLD**
  - `pkt_busy`=1, on any cycle whether or not valid is high: go to ACTIVE, `hold_cnt`←0. This rule has priority over the sample rules.
  - Above: go to ACTIVE, `hold_cnt`←0.
  - Below: `hold_cnt`+1. When the new value equals `HOLD_LEN`, go to IDLE and clear `hold_cnt`.

Outputs:
- `sens_pass` is 1 exactly when the state register is ACTIVE or HOLD.
- `sens_rise` is 1 for the single cycle after the state register moves from IDLE/ARMING to ACTIVE.
- `sens_pass_cnt` increments on each `sens_rise` and saturates at 0xFFFF. It never wraps.

Counter widths:
- `arm_cnt` is `$clog2(ARM_LEN+1)` bits.
- `hold_cnt` is `$clog2(HOLD_LEN+1)` bits.
- Neither can exceed its LEN, so no overflow is possible.

## Timing
- Reset values: state IDLE, `arm_cnt`=0, `hold_cnt`=0, `sens_pass`=0, `sens_rise`=0, `sens_pass_cnt`=0, `gate_state`=0.
- Asserting `rst` mid-operation clears everything immediately, including an open gate. No pulse is emitted.
- Open latency: `sens_pass` rises on the clock edge that samples the `ARM_LEN`-th consecutive above sample, so it is visible the next cycle. `sens_rise` is high in that same cycle.
- Close latency: `sens_pass` falls on the edge that samples the `HOLD_LEN`-th consecutive below sample with `pkt_busy` low.
- `pkt_busy` rising while in HOLD returns the state to ACTIVE on the next edge. `sens_pass` is not interrupted.
- HOLD→ACTIVE does not generate `sens_rise`.
- A below sample in ARMING on the same cycle as a threshold change uses the new threshold value.

## Structure
- Shared package `openofdm_rx_gate_pkg` holds:
  - state encodings IDLE=2'd0, ARMING=2'd1, ACTIVE=2'd2, HOLD=2'd3;
  - the `sens_pass_cnt` width constant (16).
- One natural sub-module: `sat_counter_16`, a 16-bit saturating incrementer with async active-high reset. It is used for `sens_pass_cnt`.

## Test plan
All scenarios use `ARM_LEN`=4, `HOLD_LEN`=16 and threshold 200 unless stated.
- **Basic open/close:** 4 valid samples of 210, then 16 of 150 → `sens_pass` rises the cycle after the 4th sample, with `sens_rise` a single pulse and count=1. It falls after the 16th low sample.
- **Arming interrupted:** samples 210, 210, 210, 199, then 210 ×4 → no pass after the first run. The gate opens only after the second run of 4; count=1.
- **Hold recovery and `pkt_busy`:**
  - Open the gate, send 10 low samples, then one sample of 200 → state returns to ACTIVE, with no `sens_rise` and count unchanged.
  - Repeat with `pkt_busy`=1 during 40 low samples → gate stays open throughout.
- **Sparse valid and bypass:**
  - Valid every 3rd cycle → counting advances only on valid cycles.
  - Threshold 0 with RSSI 0 → the gate opens after 4 samples.
- **Saturation and reset:**
  - Force 65 536 open/close cycles → count holds at 0xFFFF.
  - Assert `rst` while ACTIVE → all outputs are 0 immediately, asynchronously.
